// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencer for the E-stage iterative divider (DIV / DIVU). A div op that
//   is valid in E starts a radix-2 restoring divide on the operand magnitudes.
//   E is stalled until the result is ready. The result {rem, quot} is then
//   held on div_res until the E->M pipeline register captures it.
//
//   Optional feature macro: DIV_EARLY_ZERO_EN
//     When defined, a launch with a zero divisor skips the iterations. The
//     sequencer goes straight to DONE, so the stall lasts one cycle.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   e_valid      E-stage instruction valid
//   e_sig_div    E-stage instruction is DIV/DIVU
//   e_sig_sign   1 = signed (DIV), 0 = unsigned (DIVU)
//   e_reg_o1     dividend
//   e_reg_o2     divisor
//   m_allowin    M stage can accept the E instruction
//   e_stall      stall request to the E stage
//   busy         iterating (BUSY state)
//   div_res      {remainder, quotient}; valid in DONE
//
// state | meaning
// IDLE  | waiting for a div op in E; the launch cycle stalls combinationally
// BUSY  | one quotient bit per cycle, DATA_W cycles
// DONE  | result held, stall released, waiting for E->M transfer
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                e_valid,
  input  logic                e_sig_div,
  input  logic                e_sig_sign,
  input  logic [DATA_W-1:0]   e_reg_o1,
  input  logic [DATA_W-1:0]   e_reg_o2,
  input  logic                m_allowin,
  output logic                e_stall,
  output logic                busy,
  output logic [2*DATA_W-1:0] div_res
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_div;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_rem;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_zero;
  logic [2*DATA_W-1:0] r_res;

  logic                w_launch;
  logic                w_zero_b;
  logic                w_last;
  logic                w_step;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic                w_borrow;
  logic [DATA_W-1:0]   w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_launch = (r_state == S_IDLE) & e_valid & e_sig_div;
  assign w_zero_b = (e_reg_o2 == '0);
  assign w_last   = (r_cnt == LAST_CNT);
  // A cancelled op (e_valid low in BUSY) must not advance or write a result.
  assign w_step   = (r_state == S_BUSY) & e_valid;

  // The magnitude of the most negative value wraps to itself. Read as
  // unsigned, that is the correct magnitude.
  assign w_abs_a = (e_sig_sign & e_reg_o1[DATA_W-1]) ? (DATA_W'(0) - e_reg_o1) : e_reg_o1;
  assign w_abs_b = (e_sig_sign & e_reg_o2[DATA_W-1]) ? (DATA_W'(0) - e_reg_o2) : e_reg_o2;

  // Restoring step. The dividend shifts out of the top of r_quo while the
  // quotient bits shift in at the bottom. The partial remainder is always
  // less than the divisor, so the difference fits in DATA_W+1 bits.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_borrow  = w_diff[DATA_W];
  assign w_rem_nx  = w_borrow ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nx  = {r_quo[DATA_W-2:0], ~w_borrow};
  assign w_quo_fix = r_neg_q ? (DATA_W'(0) - w_quo_nx) : w_quo_nx;
  assign w_rem_fix = r_neg_r ? (DATA_W'(0) - w_rem_nx) : w_rem_nx;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
`ifdef DIV_EARLY_ZERO_EN
          w_state_nxt = w_zero_b ? S_DONE : S_BUSY;
`else
          w_state_nxt = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (!e_valid)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (e_valid & m_allowin) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    e_stall = w_launch | (r_state == S_BUSY);
    busy    = (r_state == S_BUSY);
  end

  assign div_res = r_res;

  // datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_res   <= '0;
    end else if (w_launch) begin
      r_cnt   <= '0;
      r_a     <= e_reg_o1;
      r_div   <= w_abs_b;
      r_quo   <= w_abs_a;
      r_rem   <= '0;
      r_neg_q <= e_sig_sign & (e_reg_o1[DATA_W-1] ^ e_reg_o2[DATA_W-1]);
      r_neg_r <= e_sig_sign & e_reg_o1[DATA_W-1];
      r_zero  <= w_zero_b;
`ifdef DIV_EARLY_ZERO_EN
      if (w_zero_b) r_res <= {e_reg_o1, {DATA_W{1'b1}}};
`endif
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (w_last) begin
        // Divide by zero returns the raw dividend with an all-ones quotient,
        // whatever the sign mode.
        r_res <= r_zero ? {r_a, {DATA_W{1'b1}}} : {w_rem_fix, w_quo_fix};
      end
    end
  end

endmodule
